// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 8 data bits with odd parity and stop,
// then device acknowledge. Shares the PS/2 pins open-drain with the receive path via output enables.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_TICKS = 160,
    parameter int TIMEOUT_TICKS = 24000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       clk_en,
    input  logic       START,
    input  logic [7:0] DATA,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);
    localparam int IW = $clog2(INHIBIT_TICKS + 1);
    localparam int WW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_TICKS - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;

    state_t          state;
    logic [9:0]      shift;
    logic [3:0]      bit_idx;
    logic [IW-1:0]   tick_cnt;
    logic [WW-1:0]   wd_cnt;
    logic            clk_oe, data_oe, busy, done, error;
    logic            clk_s1, clk_s2, dat_s1, dat_s2, clk_prev;
    logic            fall;

    // Raw pins are asynchronous to clk; the edge detector compares tick-to-tick samples.
    always_ff @(posedge clk) begin
        clk_s1 <= PS2_CLK_IN;
        clk_s2 <= clk_s1;
        dat_s1 <= PS2_DATA_IN;
        dat_s2 <= dat_s1;
        if (clk_en)
            clk_prev <= clk_s2;
    end

    assign fall = clk_en && clk_prev && !clk_s2;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state    <= IDLE;
            clk_oe   <= 1'b0;
            data_oe  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            bit_idx  <= '0;
            tick_cnt <= '0;
            wd_cnt   <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    clk_oe  <= 1'b0;
                    data_oe <= 1'b0;
                    // START capture is not gated by clk_en so a request is never missed.
                    if (START && !busy) begin
                        shift    <= {1'b1, ~^DATA, DATA};
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                        clk_oe   <= 1'b1;
                        state    <= INHIBIT;
                    end
                end
                INHIBIT: if (clk_en) begin
                    if (tick_cnt == INH_LAST) begin
                        tick_cnt <= '0;
                        data_oe  <= 1'b1;
                        state    <= REQ;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                REQ: if (clk_en) begin
                    clk_oe  <= 1'b0;
                    bit_idx <= '0;
                    wd_cnt  <= '0;
                    state   <= BITS;
                end
                BITS, ACK, WAIT_IDLE: if (clk_en) begin
                    // Watchdog expiry wins over any edge seen on the same tick.
                    if (wd_cnt == WD_LAST) begin
                        clk_oe  <= 1'b0;
                        data_oe <= 1'b0;
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        case (state)
                            BITS: if (fall) begin
                                data_oe <= ~shift[0];
                                shift   <= {1'b0, shift[9:1]};
                                bit_idx <= bit_idx + 1'b1;
                                if (bit_idx == 4'd9)
                                    state <= ACK;
                            end
                            ACK: if (fall) begin
                                if (!dat_s2) begin
                                    state <= WAIT_IDLE;
                                end else begin
                                    error <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end
                            WAIT_IDLE: if (clk_s2 && dat_s2) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign PS2_CLK_OE  = clk_oe;
    assign PS2_DATA_OE = data_oe;
    assign BUSY        = busy;
    assign DONE        = done;
    assign ERROR       = error;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device; expected frames and
// outcomes are queued when START is driven and compared when the transmitter reports completion.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 160;
    localparam int TMO  = 1500;
    localparam int HALF = 10;

    logic       clk = 1'b0, RESET = 1'b1, clk_en = 1'b0, START = 1'b0;
    logic [7:0] DATA = 8'h00;
    logic       PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    wire        ps2_clk_line  = ~(PS2_CLK_OE | dev_clk_low);
    wire        ps2_data_line = ~(PS2_DATA_OE | dev_data_low);

    typedef struct {
        logic [9:0] bits;
        bit         exp_err;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0, n_pass = 0;
    int inh_cnt = 0, req_cnt = 0, wd_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [9:0] dev_bits;
    bit dev_started;

    ps2_host_tx #(.INHIBIT_TICKS(INH), .TIMEOUT_TICKS(TMO)) dut (
        .clk(clk), .RESET(RESET), .clk_en(clk_en), .START(START), .DATA(DATA),
        .PS2_CLK_IN(ps2_clk_line), .PS2_DATA_IN(ps2_data_line),
        .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    always #5 clk = ~clk;

    // Tick on every other clk; it changes shortly after the rising edge.
    initial forever begin
        @(posedge clk);
        #2 clk_en = ~clk_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    // Monitor: per-tick line phases plus pulse bookkeeping, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (clk_en) begin
            if (PS2_CLK_OE && !PS2_DATA_OE) inh_cnt++;
            if (PS2_CLK_OE && PS2_DATA_OE)  req_cnt++;
            if (BUSY && !PS2_CLK_OE)        wd_cnt++;
        end
        if (DONE)  done_cnt++;
        if (ERROR) err_cnt++;
        if (DONE || ERROR) begin
            check("busy_at_pulse", {31'b0, BUSY}, 32'd0);
            check("pulse_exclusive", {31'b0, DONE & ERROR}, 32'd0);
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (clk_en) k++;
        end
        #1;
    endtask

    task automatic do_start(input logic [7:0] b);
        @(negedge clk);
        DATA  = b;
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        check("busy_after_start", {31'b0, BUSY}, 32'd1);
    endtask

    task automatic device_frame(input bit ack, input int reset_at);
        int guard = 0;
        dev_started = 1'b0;
        dev_bits    = '0;
        while (guard < 4000 && !(BUSY && !PS2_CLK_OE && PS2_DATA_OE)) begin
            @(negedge clk);
            guard++;
        end
        dev_started = (guard < 4000);
        if (!dev_started) return;
        for (int i = 0; i < 10; i++) begin
            wait_ticks(HALF);
            dev_clk_low = 1'b1;
            if (i == reset_at) begin
                wait_ticks(HALF / 2);
                @(negedge clk);
                RESET = 1'b1;
                @(negedge clk);
                check("rst_clk_oe", {31'b0, PS2_CLK_OE}, 32'd0);
                check("rst_data_oe", {31'b0, PS2_DATA_OE}, 32'd0);
                check("rst_busy", {31'b0, BUSY}, 32'd0);
                RESET = 1'b0;
                dev_clk_low = 1'b0;
                return;
            end
            wait_ticks(HALF);
            dev_bits[i] = ps2_data_line;
            dev_clk_low = 1'b0;
        end
        wait_ticks(HALF / 2);
        if (ack) dev_data_low = 1'b1;
        wait_ticks(HALF / 2);
        dev_clk_low = 1'b1;
        wait_ticks(HALF);
        dev_clk_low = 1'b0;
        wait_ticks(2);
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input bit use_dev,
                             input bit poke, input bit exp_err);
        int inh0 = inh_cnt, req0 = req_cnt, d0 = done_cnt, e0 = err_cnt, wd0;
        int guard = 0;
        exp_t e;
        do_start(b);
        sb.push_back('{frame_bits(b), exp_err});
        wd0 = wd_cnt;
        if (use_dev) begin
            fork
                device_frame(ack, -1);
                if (poke) begin
                    wait_ticks(300);
                    @(negedge clk);
                    DATA  = 8'h55;
                    START = 1'b1;
                    @(negedge clk);
                    START = 1'b0;
                    DATA  = 8'h00;
                end
            join
            check("start_bit_seen", {31'b0, dev_started}, 32'd1);
        end
        while (guard < 6000 && done_cnt + err_cnt == d0 + e0) begin
            @(negedge clk);
            guard++;
        end
        check("outcome_in_time", {31'b0, guard < 6000}, 32'd1);
        if (!use_dev) check("timeout_ticks", wd_cnt - wd0, TMO);
        repeat (40) @(negedge clk);
        if (poke) wait_ticks(400);
        e = sb.pop_front();
        if (use_dev) check($sformatf("bits_%02h", b), {22'b0, dev_bits}, {22'b0, e.bits});
        check("inhibit_ticks", inh_cnt - inh0, INH);
        check("req_ticks", req_cnt - req0, 1);
        check("done_pulses", done_cnt - d0, e.exp_err ? 0 : 1);
        check("error_pulses", err_cnt - e0, e.exp_err ? 1 : 0);
        check("clk_oe_idle", {31'b0, PS2_CLK_OE}, 32'd0);
        check("data_oe_idle", {31'b0, PS2_DATA_OE}, 32'd0);
        check("busy_idle", {31'b0, BUSY}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int d0, e0;
        repeat (4) @(negedge clk);
        check("reset_clk_oe", {31'b0, PS2_CLK_OE}, 32'd0);
        check("reset_data_oe", {31'b0, PS2_DATA_OE}, 32'd0);
        check("reset_busy", {31'b0, BUSY}, 32'd0);
        check("reset_done", {31'b0, DONE}, 32'd0);
        check("reset_error", {31'b0, ERROR}, 32'd0);
        RESET = 1'b0;
        repeat (4) @(negedge clk);

        run_frame(8'hED, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(8'hF4, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
        run_frame(8'hF4, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(8'hED, 1'b1, 1'b1, 1'b1, 1'b0);

        d0 = done_cnt;
        e0 = err_cnt;
        do_start(8'hED);
        device_frame(1'b1, 4);
        wait_ticks(300);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_error", err_cnt - e0, 0);
        check("rst_busy_after", {31'b0, BUSY}, 32'd0);
        run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
